// File: rtl/pool_result_collector.sv
// pool_result_collector: gathers one pooled map of OUT_DIM*OUT_DIM samples into a buffer and serves host reads.
// Optional POOL_COLLECT_RELU_EN stores negative samples as zero.
module pool_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_DIM = 14,
    localparam int DEPTH = OUT_DIM * OUT_DIM,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pool_in,
    input  logic                  pool_valid,
    input  logic                  pool_last,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underrun,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         count_n;
    logic                  overflow_n, underrun_n, wr;
    logic [DATA_WIDTH-1:0] sample;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef POOL_COLLECT_RELU_EN
    assign sample = pool_in[DATA_WIDTH-1] ? '0 : pool_in;
`else
    assign sample = pool_in;
`endif

    assign busy = state == COLLECT;
    assign done = state == DONE;

    always_comb begin
        state_n = state;
        count_n = count;
        overflow_n = overflow;
        underrun_n = underrun;
        wr = 1'b0;
        if (start) begin
            state_n = COLLECT;
            count_n = '0;
            overflow_n = 1'b0;
            underrun_n = 1'b0;
        end else if (state == COLLECT) begin
            // count stays below FULL here, so the increment can never wrap
            wr = pool_valid;
            count_n = count + CW'(pool_valid);
            state_n = (count_n == FULL || pool_last) ? DONE : COLLECT;
            underrun_n = pool_last && count_n < FULL;
        end else if (state == DONE) begin
            overflow_n = overflow | pool_valid;
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[count[AW-1:0]] <= sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            overflow <= 1'b0;
            underrun <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            overflow <= overflow_n;
            underrun <= underrun_n;
            rd_valid <= rd_en && state == DONE;
            // stale entries beyond the current map read as zero
            if (rd_en && state == DONE) rd_data <= (CW'(rd_addr) < count) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_pool_result_collector.sv
// tb_pool_result_collector: scenario tasks with a queue of expected read results.
module tb_pool_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pool_in = '0;
    logic        pool_valid = 1'b0;
    logic        pool_last = 1'b0;
    logic        busy, done, overflow, underrun, rd_valid;
    logic [7:0]  count;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [15:0] last_rd;
    int          tests = 0;
    int          fails = 0;

    pool_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .pool_in(pool_in), .pool_valid(pool_valid),
        .pool_last(pool_last), .busy(busy), .done(done), .count(count), .overflow(overflow),
        .underrun(underrun), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v, input logic last);
        pool_in = v;
        pool_valid = 1'b1;
        pool_last = last;
        tick();
        pool_valid = 1'b0;
        pool_last = 1'b0;
    endtask

    task automatic read_req(input logic [7:0] a, input logic [15:0] x);
        rd_en = 1'b1;
        rd_addr = a;
        exp_q.push_back(x);
        last_rd = x;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++;
        if ({busy, done, count, overflow, underrun, rd_valid, rd_data} !== 29'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b count=%0d ovf=%b und=%b rv=%b rd=%h want all zero",
                     busy, done, count, overflow, underrun, rd_valid, rd_data);
        end
        rst = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_read: got rd_valid=%b want 0", rd_valid);
        end
        feed(16'h0042, 1'b0);
        tests++;
        if (busy !== 1'b0 || count !== 8'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignore: got busy=%b count=%0d ovf=%b want 0 0 0", busy, count, overflow);
        end
    endtask

    task automatic test_full_map();
        pulse_start();
        tests++;
        if (busy !== 1'b1 || count !== 8'd0) begin
            fails++;
            $display("FAIL start_arm: got busy=%b count=%0d want 1 0", busy, count);
        end
        for (int i = 0; i < 195; i++) feed(16'(i), 1'b0);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || count !== 8'd195) begin
            fails++;
            $display("FAIL early_done: got done=%b busy=%b count=%0d want 0 1 195", done, busy, count);
        end
        feed(16'd195, 1'b0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd196 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL full_done: got done=%b busy=%b count=%0d und=%b want 1 0 196 0", done, busy, count, underrun);
        end
        read_req(8'd5, 16'd5);
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL read_5: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
        read_req(8'd195, 16'd195);
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL read_195: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
    endtask

    task automatic test_overflow();
        feed(16'hAAAA, 1'b0);
        tests++;
        if (overflow !== 1'b1 || count !== 8'd196 || done !== 1'b1) begin
            fails++;
            $display("FAIL overflow: got ovf=%b count=%0d done=%b want 1 196 1", overflow, count, done);
        end
        read_req(8'd195, 16'd195);
        read_req(8'd0, 16'd0);
        e = exp_q.pop_front();
        tests++;
        if (rd_data === 16'hAAAA || e !== 16'd195) begin
            fails++;
            $display("FAIL ovf_queue: got %h want 195", e);
        end
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL ovf_read0: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
        read_req(8'd195, 16'd195);
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL ovf_read195: got %h want %h", rd_data, e);
        end
    endtask

    task automatic test_short_map();
        pulse_start();
        tests++;
        if (overflow !== 1'b0 || count !== 8'd0) begin
            fails++;
            $display("FAIL start_clear: got ovf=%b count=%0d want 0 0", overflow, count);
        end
        for (int i = 0; i < 9; i++) feed(16'(100 + i), 1'b0);
        feed(16'd109, 1'b1);
        tests++;
        if (done !== 1'b1 || underrun !== 1'b1 || count !== 8'd10) begin
            fails++;
            $display("FAIL short_done: got done=%b und=%b count=%0d want 1 1 10", done, underrun, count);
        end
        read_req(8'd9, 16'd109);
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL short_read9: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
        read_req(8'd12, 16'd0);
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL short_read12: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
    endtask

    task automatic test_relu();
        logic [15:0] neg_exp;
`ifdef POOL_COLLECT_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hFFF0;
`endif
        pulse_start();
        rd_en = 1'b1;
        rd_addr = 8'd0;
        tick();
        rd_en = 1'b0;
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
            fails++;
            $display("FAIL collect_read: got rv=%b data=%h want 0 %h", rd_valid, rd_data, last_rd);
        end
        feed(16'hFFF0, 1'b0);
        feed(16'h0010, 1'b0);
        pool_last = 1'b1;
        tick();
        pool_last = 1'b0;
        tests++;
        if (done !== 1'b1 || underrun !== 1'b1 || count !== 8'd2) begin
            fails++;
            $display("FAIL relu_done: got done=%b und=%b count=%0d want 1 1 2", done, underrun, count);
        end
        read_req(8'd0, neg_exp);
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL relu_neg: got %h want %h", rd_data, e);
        end
        read_req(8'd1, 16'h0010);
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL relu_pos: got %h want %h", rd_data, e);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 50; i++) feed(16'(1000 + i), 1'b0);
        tests++;
        if (count !== 8'd50) begin
            fails++;
            $display("FAIL mid_count: got %0d want 50", count);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: got count=%0d busy=%b done=%b rv=%b rd=%h want 0 0 0 0 0",
                     count, busy, done, rd_valid, rd_data);
        end
        rst = 1'b0;
        tick();
        pulse_start();
        feed(16'd7, 1'b0);
        feed(16'd8, 1'b0);
        feed(16'd9, 1'b1);
        read_req(8'd0, 16'd7);
        e = exp_q.pop_front();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            fails++;
            $display("FAIL restart_read0: got rv=%b data=%h want 1 %h", rd_valid, rd_data, e);
        end
        read_req(8'd3, 16'd0);
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
            fails++;
            $display("FAIL stale_read3: got %h want %h", rd_data, e);
        end
    endtask

    task automatic test_collision();
        feed(16'h5555, 1'b0);
        start = 1'b1;
        feed(16'h1234, 1'b0);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || count !== 8'd0 || overflow !== 1'b0 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL collision: got busy=%b count=%0d ovf=%b und=%b want 1 0 0 0", busy, count, overflow, underrun);
        end
        feed(16'h0055, 1'b1);
        read_req(8'd0, 16'h0055);
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e || count !== 8'd1) begin
            fails++;
            $display("FAIL collision_read: got data=%h count=%0d want %h 1", rd_data, count, e);
        end
    endtask

    initial begin
        last_rd = '0;
        test_reset();
        test_full_map();
        test_overflow();
        test_short_map();
        test_relu();
        test_reset_mid();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
